// File: rtl/logicnet_input_quantizer_if.sv
// Stream + config bundle between the feature source and the LogicNet input quantizer.
// Pure wiring: no latency of its own.
// Flow control is carried by s_valid/s_ready and m_valid/m_ready.
interface logicnet_input_quantizer_if #(
  parameter int NUM_FEATURES = 8,
  parameter int IN_WIDTH     = 16,
  parameter int BW           = 2
);
  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  logic                         cfg_we;
  logic [FW-1:0]                cfg_feat;
  logic [BW-1:0]                cfg_sel;
  logic [IN_WIDTH-1:0]          cfg_data;
  logic                         s_valid;
  logic                         s_ready;
  logic [IN_WIDTH-1:0]          s_data;
  logic                         s_last;
  logic                         m_valid;
  logic                         m_ready;
  logic [NUM_FEATURES*BW-1:0]   m_data;
  logic                         err_len;

  // Feature source / config writer / layer-0 consumer side
  modport master (
    output cfg_we, cfg_feat, cfg_sel, cfg_data,
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, err_len
  );

  // Quantizer side
  modport slave (
    input  cfg_we, cfg_feat, cfg_sel, cfg_data,
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, err_len
  );
endinterface

// File: rtl/logicnet_input_quantizer.sv
// Quantizes raw signed features against per-feature thresholds and packs NUM_FEATURES codes.
// Latency: packed vector valid 1 clk after the last feature is accepted.
// Backpressure: s_ready drops while a vector is held for m_ready; one vector per NUM_FEATURES+1 clks.
module logicnet_input_quantizer #(
  parameter int NUM_FEATURES = 8,
  parameter int IN_WIDTH     = 16,
  parameter int BW           = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  logicnet_input_quantizer_if.slave     bus
);
  localparam int NT = (1 << BW) - 1;
  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                              state_q, state_d;
  logic [FW-1:0]                       idx_q, idx_d;
  logic [NUM_FEATURES-1:0][BW-1:0]     slots_q, slots_d;
  logic [NUM_FEATURES*BW-1:0]          m_data_q, m_data_d;
  logic                                m_valid_q, m_valid_d;
  logic                                err_len_q, err_len_d;
  logic signed [IN_WIDTH-1:0]          thr_q [NUM_FEATURES][NT];
  logic signed [IN_WIDTH-1:0]          thr_d [NUM_FEATURES][NT];
  logic [BW-1:0]                       code;
  logic                                s_ready;
  logic                                s_fire;

  // s_ready is gated by rst so nothing is accepted while reset is held
  assign s_ready     = (state_q == COLLECT) && !rst;
  assign s_fire      = bus.s_valid && s_ready;
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.err_len = err_len_q;

  // Code = number of thresholds of the current feature that the sample reaches (signed)
  always_comb begin
    code = '0;
    for (int k = 0; k < NT; k++) begin
      if ($signed(bus.s_data) >= thr_q[idx_q][k]) code = code + BW'(1);
    end
  end

  // Threshold register file; the quantizer reads thr_q, so a same-cycle write is seen next edge
  always_comb begin
    thr_d = thr_q;
    if (bus.cfg_we && (int'(bus.cfg_feat) < NUM_FEATURES) && (int'(bus.cfg_sel) < NT)) begin
      thr_d[bus.cfg_feat][bus.cfg_sel] = bus.cfg_data;
    end
  end

  // Collect/hold sequencing, slot packing and sample-length error detection
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slots_d   = slots_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    err_len_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (s_fire) begin
          slots_d[idx_q] = code;
          if (idx_q == FW'(NUM_FEATURES - 1)) begin
            // Full vector: publish it; a missing s_last is flagged but the vector still goes out
            state_d   = HOLD;
            idx_d     = '0;
            m_valid_d = 1'b1;
            m_data_d  = slots_d;
            err_len_d = !bus.s_last;
          end else if (bus.s_last) begin
            // Short sample: drop what was collected and restart at feature 0
            idx_d     = '0;
            err_len_d = 1'b1;
          end else begin
            idx_d = idx_q + FW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          state_d   = COLLECT;
          m_valid_d = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State and datapath registers; reset also clears the programmed thresholds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      slots_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      err_len_q <= 1'b0;
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int k = 0; k < NT; k++) thr_q[f][k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      slots_q   <= slots_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      err_len_q <= err_len_d;
      thr_q     <= thr_d;
    end
  end
endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Self-checking bench for logicnet_input_quantizer.
// Reference model counts reached thresholds per feature with integer arithmetic.
// Inputs driven and outputs sampled on the falling edge.
module tb_logicnet_input_quantizer;
  localparam int NF = 8;
  localparam int IW = 16;
  localparam int BW = 2;
  localparam int NT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  int   thr [NF][NT];

  logicnet_input_quantizer_if #(.NUM_FEATURES(NF), .IN_WIDTH(IW), .BW(BW)) bus();

  logicnet_input_quantizer #(.NUM_FEATURES(NF), .IN_WIDTH(IW), .BW(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_vec(input int f[NF]);
    logic [15:0] v;
    int c;
    v = '0;
    for (int i = 0; i < NF; i++) begin
      c = 0;
      for (int k = 0; k < NT; k++) if (f[i] >= thr[i][k]) c++;
      v = v | (16'(c) << (2 * i));
    end
    return v;
  endfunction

  function automatic int rnd_feat();
    return int'($urandom_range(0, 3000)) - 1500;
  endfunction

  task automatic cfg_write(input int f, input int s, input int v);
    bus.cfg_we   = 1'b1;
    bus.cfg_feat = f[2:0];
    bus.cfg_sel  = s[1:0];
    bus.cfg_data = v[15:0];
    @(negedge clk);
    bus.cfg_we = 1'b0;
    if (f < NF && s < NT) thr[f][s] = v;
  endtask

  task automatic send_beat(input int d, input bit last);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d[15:0];
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL beat_accept: s_ready=%0b, required 1 within 20 cycles", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_vec(input int f[NF], input bit with_last);
    for (int i = 0; i < NF; i++) send_beat(f[i], with_last && (i == NF - 1));
  endtask

  task automatic release_vec();
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %0b want 0", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %0b want 0", bus.m_valid); end
    checks++; if (bus.m_data !== 16'h0) begin fails++; $display("FAIL reset_m_data: got %h want 0000", bus.m_data); end
    checks++; if (bus.err_len !== 1'b0) begin fails++; $display("FAIL reset_err_len: got %0b want 0", bus.err_len); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL post_reset_s_ready: got %0b want 1", bus.s_ready); end
  endtask

  task automatic test_zero_thresholds();
    int f[NF];
    f = '{5, -1, 0, -32768, 32767, -2, 7, -7};
    send_vec(f, 1'b1);
    checks++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL zero_thr_m_valid: got %0b want 1", bus.m_valid); end
    checks++; if (bus.m_data !== 16'h3333) begin fails++; $display("FAIL zero_thr_m_data: got %h want 3333", bus.m_data); end
    checks++; if (bus.err_len !== 1'b0) begin fails++; $display("FAIL zero_thr_err_len: got %0b want 0", bus.err_len); end
    release_vec();
  endtask

  task automatic test_thresholds();
    int f[NF];
    int vals[4];
    logic [1:0] want[4];
    logic [15:0] exp;
    vals = '{50, -100, -101, 100};
    want = '{2'b10, 2'b01, 2'b00, 2'b11};
    cfg_write(0, 0, -100);
    cfg_write(0, 1, 0);
    cfg_write(0, 2, 100);
    cfg_write(0, 3, 32767);   // out-of-range threshold index, must be ignored
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < NF; i++) f[i] = rnd_feat();
      f[0] = vals[j];
      exp = model_vec(f);
      send_vec(f, 1'b1);
      checks++; if (bus.m_data[1:0] !== want[j]) begin fails++; $display("FAIL thr_code_%0d: got %b want %b", vals[j], bus.m_data[1:0], want[j]); end
      checks++; if (bus.m_data !== exp) begin fails++; $display("FAIL thr_vector_%0d: got %h want %h", j, bus.m_data, exp); end
      release_vec();
    end
  endtask

  task automatic test_backpressure();
    int f[NF];
    logic [15:0] exp;
    for (int i = 0; i < NF; i++) f[i] = rnd_feat();
    exp = model_vec(f);
    send_vec(f, 1'b1);
    for (int c = 0; c < 10; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'($urandom);
      bus.s_last  = 1'($urandom);
      @(negedge clk);
      checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL hold_s_ready c%0d: got %0b want 0", c, bus.s_ready); end
      checks++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL hold_m_valid c%0d: got %0b want 1", c, bus.m_valid); end
      checks++; if (bus.m_data !== exp) begin fails++; $display("FAIL hold_m_data c%0d: got %h want %h", c, bus.m_data, exp); end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    release_vec();
    checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL release_m_valid: got %0b want 0", bus.m_valid); end
    checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL release_s_ready: got %0b want 1", bus.s_ready); end
    for (int i = 0; i < NF; i++) f[i] = rnd_feat();
    exp = model_vec(f);
    send_vec(f, 1'b1);
    checks++; if (bus.m_data !== exp) begin fails++; $display("FAIL after_hold_m_data: got %h want %h", bus.m_data, exp); end
    release_vec();
  endtask

  task automatic test_short_sample();
    int f[NF];
    logic [15:0] exp;
    send_beat(rnd_feat(), 1'b0);
    send_beat(rnd_feat(), 1'b0);
    send_beat(rnd_feat(), 1'b1);
    checks++; if (bus.err_len !== 1'b1) begin fails++; $display("FAIL short_err_len: got %0b want 1", bus.err_len); end
    checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL short_m_valid: got %0b want 0", bus.m_valid); end
    @(negedge clk);
    checks++; if (bus.err_len !== 1'b0) begin fails++; $display("FAIL short_err_pulse: got %0b want 0", bus.err_len); end
    checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL short_no_vec: got %0b want 0", bus.m_valid); end
    for (int i = 0; i < NF; i++) f[i] = rnd_feat();
    exp = model_vec(f);
    send_vec(f, 1'b1);
    checks++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL short_next_valid: got %0b want 1", bus.m_valid); end
    checks++; if (bus.m_data !== exp) begin fails++; $display("FAIL short_next_data: got %h want %h", bus.m_data, exp); end
    checks++; if (bus.err_len !== 1'b0) begin fails++; $display("FAIL short_next_err: got %0b want 0", bus.err_len); end
    release_vec();
  endtask

  task automatic test_cfg_collision();
    int f[NF];
    logic [15:0] exp;
    for (int i = 0; i < NF; i++) f[i] = rnd_feat();
    f[0] = 50;
    exp = model_vec(f);           // old thresholds {-100,0,100} -> code 2
    bus.cfg_we   = 1'b1;
    bus.cfg_feat = 3'd0;
    bus.cfg_sel  = 2'd1;
    bus.cfg_data = 16'd60;
    send_beat(f[0], 1'b0);
    bus.cfg_we = 1'b0;
    thr[0][1] = 60;
    for (int i = 1; i < NF; i++) send_beat(f[i], i == NF - 1);
    checks++; if (bus.m_data[1:0] !== 2'b10) begin fails++; $display("FAIL collide_old_code: got %b want 10", bus.m_data[1:0]); end
    checks++; if (bus.m_data !== exp) begin fails++; $display("FAIL collide_old_vec: got %h want %h", bus.m_data, exp); end
    release_vec();
    exp = model_vec(f);           // new thresholds {-100,60,100} -> code 1
    send_vec(f, 1'b1);
    checks++; if (bus.m_data[1:0] !== 2'b01) begin fails++; $display("FAIL collide_new_code: got %b want 01", bus.m_data[1:0]); end
    checks++; if (bus.m_data !== exp) begin fails++; $display("FAIL collide_new_vec: got %h want %h", bus.m_data, exp); end
    release_vec();
  endtask

  task automatic test_back_to_back();
    int f[NF];
    logic [15:0] exp;
    bit drop;
    time t_prev;
    for (int i = 0; i < NF; i++) begin
      for (int k = 0; k < NT; k++) cfg_write(i, k, int'($urandom_range(0, 2000)) - 1000);
    end
    bus.m_ready = 1'b1;
    t_prev = 0;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NF; i++) begin
        f[i] = ($urandom_range(0, 3) == 0) ? thr[i][$urandom_range(0, NT - 1)] : rnd_feat();
      end
      drop = ($urandom_range(0, 4) == 0);
      exp  = model_vec(f);
      send_vec(f, !drop);
      checks++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid n%0d: got %0b want 1", n, bus.m_valid); end
      checks++; if (bus.m_data !== exp) begin fails++; $display("FAIL b2b_data n%0d: got %h want %h", n, bus.m_data, exp); end
      checks++; if (bus.err_len !== drop) begin fails++; $display("FAIL b2b_err_len n%0d: got %0b want %0b", n, bus.err_len, drop); end
      if (n > 0) begin
        checks++;
        if ($time - t_prev != 90) begin fails++; $display("FAIL b2b_period n%0d: got %0t want 90", n, $time - t_prev); end
      end
      t_prev = $time;
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %0b want 0", bus.m_valid); end
  endtask

  task automatic test_rst_midsample();
    int f[NF];
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) send_beat(rnd_feat(), 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'(rnd_feat());
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_s_ready: got %0b want 0", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_m_valid: got %0b want 0", bus.m_valid); end
    checks++; if (bus.err_len !== 1'b0) begin fails++; $display("FAIL rst_mid_err_len: got %0b want 0", bus.err_len); end
    for (int i = 0; i < NF; i++) begin
      for (int k = 0; k < NT; k++) thr[i][k] = 0;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NF; i++) f[i] = rnd_feat();
    f[1] = 0;
    f[2] = -1;
    exp = model_vec(f);
    send_vec(f, 1'b1);
    checks++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL rst_next_valid: got %0b want 1", bus.m_valid); end
    checks++; if (bus.m_data !== exp) begin fails++; $display("FAIL rst_next_data: got %h want %h", bus.m_data, exp); end
    checks++; if (bus.err_len !== 1'b0) begin fails++; $display("FAIL rst_next_err: got %0b want 0", bus.err_len); end
    release_vec();
  endtask

  initial begin
    bus.cfg_we   = 1'b0;
    bus.cfg_feat = '0;
    bus.cfg_sel  = '0;
    bus.cfg_data = '0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_last   = 1'b0;
    bus.m_ready  = 1'b0;
    for (int i = 0; i < NF; i++) begin
      for (int k = 0; k < NT; k++) thr[i][k] = 0;
    end
    test_reset();
    test_zero_thresholds();
    test_thresholds();
    test_backpressure();
    test_short_sample();
    test_cfg_collision();
    test_back_to_back();
    test_rst_midsample();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
